// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for the five-stage core's register walls.
// Produces the memory-wait freeze, the load-use bubble, the branch squash,
// the execute-stage forwarding selects, a saturating stall-cycle counter
// and a sticky memory-timeout flag. State moves on the falling clock edge,
// the same edge that clocks the register walls.
// WAIT_TIMEOUT is expected to be at least 2.
module hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_ra_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_use_ra,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_ra_addr,
  input  logic [4:0]       ex_rt_addr,
  input  logic             ex_do_dm_read,
  input  logic [4:0]       ex_write_reg_addr,
  input  logic             ex_branch_taken,
  input  logic             mem_do_reg_write,
  input  logic [4:0]       mem_write_reg_addr,
  input  logic             wb_do_reg_write,
  input  logic [4:0]       wb_write_reg_addr,
  input  logic             dm_req,
  input  logic             dm_ack,
  output logic             do_hazard,
  output logic             do_flush_REG1,
  output logic             do_stall,
  output logic [1:0]       fwd_ra_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             flush_pending_q, flush_pending_d;
  logic             timeout_q, timeout_d;
  // Set when an access times out; keeps a still-asserted dm_req of the
  // abandoned access from starting a fresh stall.
  logic             abandon_q, abandon_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             stall;
  logic             load_use;
  logic             hazard;
  logic             flush;

  // State register and all counters/flags, updated with the walls.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q         <= RUN;
      wait_q          <= '0;
      flush_pending_q <= 1'b0;
      timeout_q       <= 1'b0;
      abandon_q       <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      flush_pending_q <= flush_pending_d;
      timeout_q       <= timeout_d;
      abandon_q       <= abandon_d;
      cnt_q           <= cnt_d;
    end
  end

  // Memory-wait FSM: next state, wait counter, timeout and the freeze.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    abandon_d = abandon_q;
    stall     = 1'b0;
    case (state_q)
      RUN: begin
        if (abandon_q) begin
          if (!dm_req || dm_ack) begin
            abandon_d = 1'b0;
          end
        end else if (dm_req && !dm_ack) begin
          stall   = 1'b1;
          wait_d  = WCW'(1);
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dm_ack) begin
          wait_d  = '0;
          state_d = RUN;
        end else begin
          stall = 1'b1;
          if (wait_q == WAIT_LAST) begin
            // This cycle is the last allowed wait: give up on the access.
            timeout_d = 1'b1;
            abandon_d = 1'b1;
            wait_d    = '0;
            state_d   = RUN;
          end else begin
            wait_d = wait_q + WCW'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Load-use bubble and branch squash, with freeze > bubble > squash.
  always_comb begin
    load_use = ex_do_dm_read && (ex_write_reg_addr != 5'd0) &&
               ((id_use_ra && (id_ra_addr == ex_write_reg_addr)) ||
                (id_use_rt && (id_rt_addr == ex_write_reg_addr)));
    hazard   = load_use && !stall;
    flush    = (ex_branch_taken || flush_pending_q) && !stall && !hazard;
    // A suppressed branch is remembered until its single flush goes out.
    flush_pending_d = flush_pending_q;
    if (flush) begin
      flush_pending_d = 1'b0;
    end else if (ex_branch_taken) begin
      flush_pending_d = 1'b1;
    end
  end

  // Saturating count of frozen or bubbled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if ((stall || hazard) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Forwarding: operand 0 is ra, operand 1 is rt. Memory stage wins over
  // writeback; r0 is hard-wired zero and never forwarded.
  logic [4:0] ex_src_addr [2];
  logic [1:0] fwd_sel     [2];

  assign ex_src_addr[0] = ex_ra_addr;
  assign ex_src_addr[1] = ex_rt_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      assign mem_hit = mem_do_reg_write && (mem_write_reg_addr != 5'd0) &&
                       (mem_write_reg_addr == ex_src_addr[gi]);
      assign wb_hit  = wb_do_reg_write && (wb_write_reg_addr != 5'd0) &&
                       (wb_write_reg_addr == ex_src_addr[gi]);
      assign fwd_sel[gi] = mem_hit ? 2'd1 : (wb_hit ? 2'd2 : 2'd0);
    end
  endgenerate

  assign fwd_ra_sel    = fwd_sel[0];
  assign fwd_rt_sel    = fwd_sel[1];
  assign do_stall      = stall;
  assign do_hazard     = hazard;
  assign do_flush_REG1 = flush;
  assign stall_count   = cnt_q;
  assign mem_timeout   = timeout_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the five-stage core's register walls. Generates the wall control signals do_hazard (load-use bubble) and do_flush_REG1 (taken-branch squash), plus a global freeze (do_stall) for data-memory wait states. Also produces ALU operand forwarding selects for the execute stage, and keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
Sits beside the register-wall block; all its state updates on the same clock edge as the walls (negedge clock).

Parameters:
WAIT_TIMEOUT, 64, maximum consecutive memory-wait cycles before mem_timeout is set.
CNT_W, 16, width of stall_count.

Ports:
clock  in  1  core clock; all state updates on negedge.
reset  in  1  synchronous, active-high.
id_ra_addr  in  5  ra source register of instruction at wall 1 output.
id_rt_addr  in  5  rt source register of instruction at wall 1 output.
id_use_ra  in  1  decode stage reads ra.
id_use_rt  in  1  decode stage reads rt.
ex_ra_addr  in  5  ra address of instruction in execute.
ex_rt_addr  in  5  rt address of instruction in execute.
ex_do_dm_read  in  1  execute-stage instruction is a load.
ex_write_reg_addr  in  5  execute-stage destination register.
ex_branch_taken  in  1  execute resolved a taken branch/jump.
mem_do_reg_write  in  1  memory-stage instruction writes a register.
mem_write_reg_addr  in  5  memory-stage destination register.
wb_do_reg_write  in  1  writeback-stage instruction writes a register.
wb_write_reg_addr  in  5  writeback-stage destination register.
dm_req  in  1  memory stage is issuing a read or write.
dm_ack  in  1  data memory completes the access this cycle.
do_hazard  out  1  hold wall 1, bubble wall 2.
do_flush_REG1  out  1  zero wall 1.
do_stall  out  1  freeze all walls.
fwd_ra_sel  out  2  0 = regfile, 1 = memory-stage ALU result, 2 = writeback data.
fwd_rt_sel  out  2  same encoding as fwd_ra_sel.
stall_count  out  CNT_W  saturating count of do_stall/do_hazard cycles.
mem_timeout  out  1  sticky flag, set on memory-wait timeout.

Behaviour:
- Reset (sampled on negedge while reset=1):
  - State goes to RUN; all counters cleared; flush_pending cleared; mem_timeout cleared.
  - All outputs read 0 in the cycle following reset.
- States: RUN, MEM_WAIT.
- RUN:
  - dm_req=1 and dm_ack=0: do_stall=1 combinationally, wait counter goes to 1, next state MEM_WAIT.
  - dm_req=1 and dm_ack=1: zero-wait access; no stall.
- MEM_WAIT:
  - do_stall=1 while dm_ack=0; wait counter increments each cycle.
  - dm_ack=1: do_stall=0 that cycle, counter cleared, next state RUN.
  - Counter reaching WAIT_TIMEOUT: mem_timeout is set and held until reset, and the state is forced back to RUN. The stalled access is abandoned; no further stall is issued for it.
- Load-use detection (combinational): load_use = ex_do_dm_read AND ex_write_reg_addr != 0 AND ((id_use_ra AND id_ra_addr == ex_write_reg_addr) OR (id_use_rt AND id_rt_addr == ex_write_reg_addr)).
- Output priority: do_stall > do_hazard > do_flush_REG1. Lower-priority outputs are forced to 0 while a higher one is active.
  - do_hazard = load_use AND NOT do_stall.
  - do_flush_REG1 = (ex_branch_taken OR flush_pending) AND NOT do_stall AND NOT do_hazard.
- flush_pending:
  - Set when ex_branch_taken=1 but the flush is suppressed by do_stall or do_hazard.
  - Cleared in the cycle do_flush_REG1 is asserted.
  - Guarantees exactly one flush per taken branch.
  - Branch and load-use in the same cycle: bubble first, flush in the next non-stalled cycle.
- Forwarding (combinational, per operand X in {ra, rt}):
  - sel=1 if mem_do_reg_write AND mem_write_reg_addr != 0 AND mem_write_reg_addr == ex_X_addr.
  - Else sel=2 if the same conditions hold for the wb_ signals.
  - Else sel=0.
  - Memory stage has priority over writeback; register 0 is never forwarded; value 3 is never driven.
- stall_count: increments on every negedge where do_stall OR do_hazard is 1; saturates at all-ones; no wrap.
- do_flush_REG1 and do_hazard are never 1 in the same cycle; do_stall excludes both.

Test Plan:
- Load r3 in execute (ex_do_dm_read=1, ex_write_reg_addr=3); decode reads r3 via rt (id_use_rt=1, id_rt_addr=3) -> do_hazard=1 for one cycle. Load with ex_write_reg_addr=0 -> do_hazard=0.
- Forwarding: mem writes r5, wb writes r5, ex_ra_addr=5 -> fwd_ra_sel=1. mem writes r0, wb writes r0, ex_ra_addr=0 -> fwd_ra_sel=0. Only wb writes r7, ex_rt_addr=7 -> fwd_rt_sel=2.
- dm_req=1, dm_ack=0 for 3 cycles then 1 -> do_stall=1 for exactly 3 cycles, 0 on the ack cycle, state back to RUN, stall_count=3.
- ex_branch_taken=1 during a MEM_WAIT stall -> do_flush_REG1=0 while stalled, then exactly one pulse of 1 in the first unstalled cycle; flush_pending=0 afterwards.
- dm_ack held 0 for WAIT_TIMEOUT=64 cycles -> mem_timeout=1, do_stall drops, mem_timeout stays 1 until reset.
- Assert reset mid-MEM_WAIT with stall_count=10 -> next cycle: do_stall=0, stall_count=0, mem_timeout=0; stall_count preset near max saturates at 0xFFFF.
